fft8_input_framer: RTL and testbench
====================================

# fft8_input_framer

Upstream feeder for the 8-point radix-2 FFT. Accepts a stream of 16-bit real samples over a valid/ready handshake and packs them into 8-sample frames in two ping-pong banks. Launches the FFT with a one-cycle `start_o` pulse and holds the frame stable on `x_0_o..x_7_o` until the FFT reports `valid`. Sits between the sample source and the FFT top's `start_i`/`x_*_i`/`valid_o`/`busy_o` ports.

## Interface
- `DATA_W`, 16, sample width; must match FFT input width.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_data_i` in DATA_W: input sample.
- `s_valid_i` in 1: sample present.
- `s_last_i` in 1: marks the final sample of a frame; qualified by a transfer.
- `s_ready_o` out 1: framer can accept a sample this cycle.
- `fft_busy_i` in 1: FFT `busy_o`.
- `fft_valid_i` in 1: FFT `valid_o`; one-cycle pulse at result.
- `start_o` out 1: one-cycle launch pulse to FFT `start_i`.
- `x_0_o` … `x_7_o` out DATA_W each: frame to FFT `x_0_i..x_7_i`.
- `frame_err_o` out 1: one-cycle pulse on a framing error.
- `frame_cnt_o` out 8: frames launched, wraps 255→0.

## Operation
- Transfer = `s_valid_i && s_ready_o` at a rising edge.
- Two banks (0/1), 8 × DATA_W each, each in state FREE, FULL or INUSE. Write pointer `wr_bank`, index `wr_idx` 0..7; read pointer `rd_bank`.
- `s_ready_o = (bank[wr_bank] == FREE)`, combinational from registers.
- A transfer writes `bank[wr_bank][wr_idx]` and increments `wr_idx`. A transfer at `wr_idx==7` marks the bank FULL, clears `wr_idx`, and toggles `wr_bank`.
- Framing:
  - `s_last_i` on a transfer with `wr_idx<7`: `frame_err_o` pulses; the partial frame is discarded (`wr_idx`←0, bank stays FREE, the current sample is dropped).
  - `wr_idx==7` without `s_last_i`: `frame_err_o` pulses, but the frame is still committed FULL.
- Launch FSM, states IDLE and RUN:
  - IDLE → RUN when `bank[rd_bank]==FULL && !fft_busy_i`. At that edge `start_o`←1 for exactly one cycle, the bank becomes INUSE, and `frame_cnt_o` increments.
  - RUN → IDLE on `fft_valid_i`. At that edge `bank[rd_bank]`←FREE and `rd_bank` toggles.
  - `fft_valid_i` in IDLE is ignored. `fft_busy_i` is not used to leave RUN.
- `x_k_o = bank[rd_bank][k]` (combinational mux). The values are stable throughout RUN because an INUSE bank is never written.
- Banks are launched strictly in fill order.

## Timing
- Reset values: `start_o`=0, `frame_err_o`=0, `frame_cnt_o`=0, `x_*_o`=0 (banks cleared), `s_ready_o`=1 after reset, FSM=IDLE, both pointers 0, `wr_idx`=0, both banks FREE.
- Launch latency:
  - 8th transfer at edge E → bank FULL after E.
  - With FSM in IDLE and FFT not busy, `start_o` is high in the cycle after edge E+1. `x_*_o` is valid in that same cycle.
- Release:
  - `fft_valid_i` sampled at edge R → freed bank is writable (`s_ready_o`=1) from cycle R+.
  - The earliest next `start_o` follows edge R+1. At least one IDLE cycle always separates launches.
- Simultaneous events:
  - 8th sample into one bank in the same cycle as `fft_valid_i` for the other: both take effect at the same edge.
  - The launch condition is evaluated in the following IDLE cycle.
- Both banks FULL/INUSE: `s_ready_o`=0 until release. No overflow is possible and no samples are lost.
- `rst` asserted mid-frame or in RUN: all state is cleared immediately. Any in-flight FFT result is ignored until the next launch.
- Deassertion of `rst` is synchronised externally; no internal reset synchroniser.

## Structure
- Package `fft8_pkg`:
  - `DATA_W` default and `N_PTS=8`.
  - `bank_state_t` {FREE, FULL, INUSE}.
  - `launch_state_t` {IDLE, RUN}.
- Sub-module `fft8_sample_bank`, instantiated twice:
  - 8 × DATA_W storage, write port (index + enable), 8-wide parallel read.
  - Owns its `bank_state_t` register, with set-full, set-inuse and release strobes.
- The top holds the pointers, framing check, launch FSM and output mux.

## Test plan
- Reset, then feed 1..8 (`s_last_i` on 8), FFT idle → `start_o` one-cycle pulse 2 cycles after the 8th transfer; `x_0_o..x_7_o`=1..8; `frame_cnt_o`=1.
- Feed 24 samples back-to-back with `fft_valid_i` withheld → 16 accepted, `s_ready_o` low from the 17th cycle. One `fft_valid_i` → ready returns next cycle; the second bank (9..16) launches after one IDLE cycle.
- `s_last_i` on the 5th sample → `frame_err_o` pulse, no launch. The next 8 samples (with last) launch as a clean frame.
- 8 samples with no `s_last_i` → `frame_err_o` pulse, frame still launched.
- `fft_busy_i` high when the bank becomes FULL → no `start_o` until `fft_busy_i` falls, then a pulse next cycle. `x_*_o` stays unchanged through RUN while the other bank fills.
- Assert `rst` low in RUN with 4 samples in the other bank → all outputs zero asynchronously. After release, 8 fresh samples launch with `frame_cnt_o`=1.
- 256 launches → `frame_cnt_o` wraps to 0.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types and sizes for the FFT-8 input framer and its sample banks.
package fft8_pkg;

  localparam int DATA_W = 16;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = $clog2(N_PTS);

  // Life cycle of one ping-pong bank: being filled, waiting for launch, held for the FFT.
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FULL  = 2'd1,
    INUSE = 2'd2
  } bank_state_t;

  // Launch sequencer: waiting for a full bank, or waiting for the FFT result.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } launch_state_t;

endpackage

// File: rtl/fft8_sample_bank.sv
// One 8-sample frame buffer with a single write port, a parallel read of all
// samples, and its own FREE/FULL/INUSE occupancy state.
module fft8_sample_bank #(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [fft8_pkg::IDX_W-1:0]              wr_idx,
  input  logic [DATA_W-1:0]                       wr_data,
  input  logic                                    set_full,
  input  logic                                    set_inuse,
  input  logic                                    release_bank,
  output fft8_pkg::bank_state_t                   state,
  output logic [fft8_pkg::N_PTS-1:0][DATA_W-1:0]  rd_data
);
  import fft8_pkg::*;

  logic [N_PTS-1:0][DATA_W-1:0] mem;

  // Sample storage: one word written per accepted sample.
  // NOTE: the storage is reset (not left undefined) because the frame outputs must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking assignment keeps every register update in step at the clock edge.
      mem[wr_idx] <= wr_data;
    end
  end

  // Occupancy state; the strobes never coincide because each applies to a different state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
    end else if (release_bank) begin
      state <= FREE;
    end else if (set_inuse) begin
      state <= INUSE;
    end else if (set_full) begin
      state <= FULL;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/fft8_input_framer.sv
// Packs a valid/ready sample stream into 8-sample frames across two ping-pong
// banks, checks frame boundaries against s_last_i, and launches the FFT one
// frame at a time while holding the frame stable until the FFT reports done.
module fft8_input_framer #(
  parameter int DATA_W = fft8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  input  logic              fft_busy_i,
  input  logic              fft_valid_i,
  output logic              start_o,
  output logic [DATA_W-1:0] x_0_o,
  output logic [DATA_W-1:0] x_1_o,
  output logic [DATA_W-1:0] x_2_o,
  output logic [DATA_W-1:0] x_3_o,
  output logic [DATA_W-1:0] x_4_o,
  output logic [DATA_W-1:0] x_5_o,
  output logic [DATA_W-1:0] x_6_o,
  output logic [DATA_W-1:0] x_7_o,
  output logic              frame_err_o,
  output logic [7:0]        frame_cnt_o
);
  import fft8_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  logic                         wr_bank;
  logic                         rd_bank;
  logic [IDX_W-1:0]             wr_idx;
  launch_state_t                state;

  bank_state_t                  bank_state [2];
  logic [N_PTS-1:0][DATA_W-1:0] bank_data  [2];
  logic [N_PTS-1:0][DATA_W-1:0] rd_frame;

  logic                         xfer;
  logic                         at_last;
  logic                         early_last;
  logic                         launch;
  logic                         done;
  logic [1:0]                   wr_en;
  logic [1:0]                   set_full;
  logic [1:0]                   set_inuse;
  logic [1:0]                   release_bank;

  assign s_ready_o = (bank_state[wr_bank] == FREE);

  // Handshake decode, framing check and per-bank strobe steering.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_en        = '0;
    set_full     = '0;
    set_inuse    = '0;
    release_bank = '0;
    xfer         = s_valid_i && s_ready_o;
    at_last      = (wr_idx == LAST_IDX);
    early_last   = xfer && s_last_i && !at_last;
    launch       = (state == IDLE) && (bank_state[rd_bank] == FULL) && !fft_busy_i;
    done         = (state == RUN) && fft_valid_i;
    // An early s_last_i drops the current sample along with the partial frame.
    wr_en[wr_bank]        = xfer && !early_last;
    set_full[wr_bank]     = xfer && at_last;
    set_inuse[rd_bank]    = launch;
    release_bank[rd_bank] = done;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_sample_bank #(
      .DATA_W(DATA_W)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en[b]),
      .wr_idx       (wr_idx),
      .wr_data      (s_data_i),
      .set_full     (set_full[b]),
      .set_inuse    (set_inuse[b]),
      .release_bank (release_bank[b]),
      .state        (bank_state[b]),
      .rd_data      (bank_data[b])
    );
  end

  // Write/read pointers and the framing-error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_bank     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= xfer && (s_last_i != at_last);
      if (xfer) begin
        if (at_last || early_last) begin
          wr_idx <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
        if (at_last) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Launch FSM with registered start pulse and launch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      start_o     <= 1'b0;
      frame_cnt_o <= 8'd0;
    end else begin
      start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= RUN;
            start_o     <= 1'b1;
            frame_cnt_o <= frame_cnt_o + 8'd1;
          end
        end
        RUN: begin
          // Busy is deliberately ignored here; only the result pulse ends a run.
          if (fft_valid_i) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // The FFT always sees the bank at the read pointer; it cannot change while INUSE.
  assign rd_frame = bank_data[rd_bank];
  assign x_0_o    = rd_frame[0];
  assign x_1_o    = rd_frame[1];
  assign x_2_o    = rd_frame[2];
  assign x_3_o    = rd_frame[3];
  assign x_4_o    = rd_frame[4];
  assign x_5_o    = rd_frame[5];
  assign x_6_o    = rd_frame[6];
  assign x_7_o    = rd_frame[7];

endmodule

// File: tb/tb_fft8_input_framer.sv
// Scoreboard bench for fft8_input_framer: a frame-level model of the sample
// stream predicts committed frames, framing errors and back-pressure; a monitor
// compares every launch, every cycle of ready/error and frame stability.
module tb_fft8_input_framer;
  import fft8_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] s_data_i = '0;
  logic         s_valid_i = 1'b0;
  logic         s_last_i = 1'b0;
  logic         s_ready_o;
  logic         fft_busy_i;
  logic         fft_valid_i;
  logic         start_o;
  logic [W-1:0] x_0_o, x_1_o, x_2_o, x_3_o, x_4_o, x_5_o, x_6_o, x_7_o;
  logic         frame_err_o;
  logic [7:0]   frame_cnt_o;

  // Manual and autonomous FFT stand-ins are kept on separate variables.
  logic man_busy = 1'b0, man_valid = 1'b0;
  logic auto_busy = 1'b0, auto_valid = 1'b0;
  bit   auto_fft = 1'b0;
  assign fft_busy_i  = man_busy | auto_busy;
  assign fft_valid_i = man_valid | auto_valid;

  always #5 clk = ~clk;

  fft8_input_framer #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .fft_busy_i  (fft_busy_i),
    .fft_valid_i (fft_valid_i),
    .start_o     (start_o),
    .x_0_o       (x_0_o),
    .x_1_o       (x_1_o),
    .x_2_o       (x_2_o),
    .x_3_o       (x_3_o),
    .x_4_o       (x_4_o),
    .x_5_o       (x_5_o),
    .x_6_o       (x_6_o),
    .x_7_o       (x_7_o),
    .frame_err_o (frame_err_o),
    .frame_cnt_o (frame_cnt_o)
  );

  logic [W-1:0] x_out [8];
  assign x_out[0] = x_0_o;
  assign x_out[1] = x_1_o;
  assign x_out[2] = x_2_o;
  assign x_out[3] = x_3_o;
  assign x_out[4] = x_4_o;
  assign x_out[5] = x_5_o;
  assign x_out[6] = x_6_o;
  assign x_out[7] = x_7_o;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [W-1:0] s [8];
    logic [7:0]   cnt;
  } frame_t;

  frame_t       sb [$];        // committed frames awaiting launch, fill order
  logic [W-1:0] partial [$];   // samples of the frame being assembled
  int           held = 0;      // frames committed and not yet released by the FFT
  logic [7:0]   commit_no = '0;
  bit           running = 1'b0;
  bit           err_pending = 1'b0;
  bit           prev_start = 1'b0;
  bit           wrap_seen = 1'b0;
  int           launches = 0;
  int           err_seen = 0;
  logic [W-1:0] cur [8];
  frame_t       f_pop;
  frame_t       f_new;

  // Monitor: compare the current cycle, then apply what the next edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      partial.delete();
      held        = 0;
      commit_no   = '0;
      running     = 1'b0;
      err_pending = 1'b0;
      prev_start  = 1'b0;
      launches    = 0;
    end else begin
      check("ready", 32'(s_ready_o), 32'(held < 2));
      check("frame_err", 32'(frame_err_o), 32'(err_pending));
      if (frame_err_o) err_seen++;
      if (start_o) begin
        launches++;
        check("start_width", 32'(prev_start), 32'(1'b0));
        check("start_has_frame", 32'(sb.size() > 0), 32'(1'b1));
        if (sb.size() > 0) begin
          f_pop = sb.pop_front();
          for (int k = 0; k < 8; k++) check($sformatf("x_launch[%0d]", k), 32'(x_out[k]), 32'(f_pop.s[k]));
          check("frame_cnt", 32'(frame_cnt_o), 32'(f_pop.cnt));
          if (f_pop.cnt == 8'd0) wrap_seen = 1'b1;
          cur = f_pop.s;
        end
        running = 1'b1;
      end else if (running) begin
        for (int k = 0; k < 8; k++) check($sformatf("x_stable[%0d]", k), 32'(x_out[k]), 32'(cur[k]));
      end
      prev_start = start_o;

      err_pending = 1'b0;
      if (s_valid_i && held < 2) begin
        if (s_last_i && partial.size() < 7) begin
          err_pending = 1'b1;
          partial.delete();
        end else begin
          partial.push_back(s_data_i);
          if (partial.size() == 8) begin
            err_pending = !s_last_i;
            commit_no   = commit_no + 8'd1;
            for (int k = 0; k < 8; k++) f_new.s[k] = partial[k];
            f_new.cnt = commit_no;
            sb.push_back(f_new);
            held++;
            partial.delete();
          end
        end
      end
      if (fft_valid_i && running) begin
        running = 1'b0;
        held--;
      end
    end
  end

  // Autonomous FFT: busy after launch, result after a random latency, busy lingers a little.
  always begin
    @(negedge clk);
    if (auto_fft && rst && start_o) begin
      @(posedge clk);
      #1 auto_busy = 1'b1;
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 auto_valid = 1'b1;
      @(posedge clk);
      #1 auto_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 auto_busy = 1'b0;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    bit acc = 1'b0;
    s_data_i  = d;
    s_last_i  = last;
    s_valid_i = 1'b1;
    for (int c = 0; c < 2000 && !acc; c++) begin
      @(negedge clk);
      acc = s_ready_o;
      @(posedge clk);
      #1;
    end
    check("send_accept", 32'(acc), 32'(1'b1));
  endtask

  task automatic fft_done();
    @(posedge clk);
    #1 man_valid = 1'b1;
    @(posedge clk);
    #1 man_valid = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (start_o) break;
    end
    check(name, 32'(start_o), 32'(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(start_o), 32'(1'b0));
    check({tag, "_err"}, 32'(frame_err_o), 32'(1'b0));
    check({tag, "_cnt"}, 32'(frame_cnt_o), 32'd0);
    check({tag, "_ready"}, 32'(s_ready_o), 32'(1'b1));
    for (int k = 0; k < 8; k++) check($sformatf("%s_x[%0d]", tag, k), 32'(x_out[k]), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int sent = 0;
  int e0, s0, frames;
  int mode, len;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    sync();

    // T1: single frame 1..8, launch exactly two edges after the 8th transfer
    for (int i = 1; i <= 8; i++) send(W'(i), i == 8);
    s_valid_i = 1'b0;
    @(negedge clk);
    check("t1_start_early", 32'(start_o), 32'(1'b0));
    @(negedge clk);
    check("t1_start_lat", 32'(start_o), 32'(1'b1));
    @(negedge clk);
    check("t1_start_pulse", 32'(start_o), 32'(1'b0));
    fft_done();

    // T2: 24 back-to-back samples with the result withheld
    fork
      begin
        for (int i = 1; i <= 24; i++) begin
          send(W'(i), (i % 8) == 0);
          sent++;
        end
        s_valid_i = 1'b0;
      end
      begin
        wait_start("t2_launch1");
        repeat (20) @(negedge clk);
        check("t2_blocked", 32'(s_ready_o), 32'(1'b0));
        check("t2_accepted", 32'(sent), 32'd16);
        fft_done();
        @(negedge clk);
        check("t2_ready_back", 32'(s_ready_o), 32'(1'b1));
        check("t2_idle_gap", 32'(start_o), 32'(1'b0));
        @(negedge clk);
        check("t2_launch2", 32'(start_o), 32'(1'b1));
      end
    join
    fft_done();
    wait_start("t2_launch3");
    fft_done();

    // T3: early s_last_i discards the partial frame
    e0 = err_seen;
    s0 = launches;
    for (int i = 1; i <= 5; i++) send(W'(100 + i), i == 5);
    s_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_err", 32'(err_seen - e0), 32'd1);
    check("t3_no_launch", 32'(launches - s0), 32'd0);
    sync();
    for (int i = 1; i <= 8; i++) send(W'(200 + i), i == 8);
    s_valid_i = 1'b0;
    wait_start("t3_clean_launch");
    check("t3_err_once", 32'(err_seen - e0), 32'd1);
    fft_done();

    // T4: missing s_last_i still commits the frame
    e0 = err_seen;
    for (int i = 1; i <= 8; i++) send(W'(250 + i), 1'b0);
    s_valid_i = 1'b0;
    wait_start("t4_launch");
    check("t4_err", 32'(err_seen - e0), 32'd1);
    fft_done();

    // T5: busy FFT holds off the launch; frame stays stable while the other bank fills
    man_busy = 1'b1;
    s0 = launches;
    for (int i = 1; i <= 8; i++) send(W'(300 + i), i == 8);
    s_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_held_off", 32'(launches - s0), 32'd0);
    sync();
    man_busy = 1'b0;
    @(negedge clk);
    check("t5_not_yet", 32'(start_o), 32'(1'b0));
    @(negedge clk);
    check("t5_launch", 32'(start_o), 32'(1'b1));
    sync();
    for (int i = 1; i <= 8; i++) send(W'(400 + i), i == 8);
    s_valid_i = 1'b0;
    fft_done();
    wait_start("t5_launch2");
    fft_done();

    // T6: reset during RUN with a partly filled second bank
    for (int i = 1; i <= 8; i++) send(W'(500 + i), i == 8);
    s_valid_i = 1'b0;
    wait_start("t6_launch");
    sync();
    for (int i = 1; i <= 4; i++) send(W'(600 + i), 1'b0);
    s_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_all_zero("t6_async");
    sync();
    rst = 1'b1;
    fft_done();  // stale result while IDLE must be ignored
    for (int i = 1; i <= 8; i++) send(W'(700 + i), i == 8);
    s_valid_i = 1'b0;
    wait_start("t6_relaunch");
    fft_done();

    // T7: randomized stream with autonomous FFT until the launch counter wraps
    auto_fft = 1'b1;
    frames   = 0;
    while (launches < 262 && frames < 450) begin
      mode = $urandom_range(0, 9);
      len  = (mode == 0) ? $urandom_range(1, 7) : 8;
      for (int j = 0; j < len; j++) begin
        send(W'($urandom), (mode == 0) ? (j == len - 1) : ((mode == 1) ? 1'b0 : (j == 7)));
        if ($urandom_range(0, 3) == 0) begin
          s_valid_i = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
      frames++;
    end
    s_valid_i = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !running) break;
    end
    check("t7_drained", 32'(sb.size()), 32'd0);
    check("t7_wrap_seen", 32'(wrap_seen), 32'(1'b1));
    check("t7_cnt_final", 32'(frame_cnt_o), 32'(launches % 256));

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
